// File: rtl/busy_arbiter_if.sv
// -----------------------------------------------------------------------------
// busy_arbiter_if
//
// Request/grant bundle between the requesting control blocks and the
// busy_arbiter scheduler.
//
// Parameters:
//   NREQ  number of requesters
//   IDW   owner index width (2**IDW >= NREQ)
//
// Signals:
//   i_req    level request per requester          (requesters -> arbiter)
//   o_grant  one-hot grant for the busy window    (arbiter -> requesters)
//   o_busy   high while any grant is active       (arbiter -> requesters)
//   o_owner  index of current/last grantee        (arbiter -> requesters)
//   o_done   one-cycle pulse in the last grant cycle (arbiter -> requesters)
//
// Modports:
//   master  requester side, drives i_req
//   slave   arbiter side, drives the grant outputs
// -----------------------------------------------------------------------------
interface busy_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0] i_req;
    logic [NREQ-1:0] o_grant;
    logic            o_busy;
    logic [IDW-1:0]  o_owner;
    logic [NREQ-1:0] o_done;

    modport master (output i_req, input o_grant, o_busy, o_owner, o_done);
    modport slave  (input i_req, output o_grant, o_busy, o_owner, o_done);
endinterface

// File: rtl/busy_arbiter.sv
// -----------------------------------------------------------------------------
// busy_arbiter
//
// Round-robin scheduler sharing one fixed-length, non-retriggerable busy window
// of DURATION cycles among NREQ requesters. Each grant owns the resource for
// exactly DURATION cycles; then the next pending requester is served in
// rotating order, the previous grantee having lowest priority.
//
// Optional feature macro: TIMER_ARB_GAP_EN
//   defined   -> one idle GAP cycle (o_grant=0, o_busy=0) after every grant;
//                arbitration happens in that GAP cycle.
//   undefined -> back-to-back grants with no bubble.
// With FORMAL defined, the output invariants are asserted.
//
// Parameters:
//   NREQ      number of requesters (2..16)
//   DURATION  grant length in cycles (1..65535)
//   IDW       owner index width (2**IDW >= NREQ)
//
// Ports:
//   i_clk    clock, rising edge
//   i_reset  asynchronous active-high reset
//   bus      busy_arbiter_if slave modport (i_req in; o_grant, o_busy,
//            o_owner, o_done out -- all registered)
// -----------------------------------------------------------------------------
module busy_arbiter #(
    parameter int          NREQ     = 4,
    parameter int unsigned DURATION = 22,
    parameter int          IDW      = 2
) (
    input  logic           i_clk,
    input  logic           i_reset,
    busy_arbiter_if.slave  bus
);

`ifdef TIMER_ARB_GAP_EN
    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
`else
    typedef enum logic {IDLE, RUN} state_t;
`endif

    localparam logic [15:0] CNT_LOAD = 16'(DURATION - 1);
    // A one-cycle grant is also its own done cycle.
    localparam bit DONE_ON_LOAD = (DURATION == 1);

    state_t          state;
    logic [15:0]     count;
    logic [NREQ-1:0] grant;
    logic            busy;
    logic [IDW-1:0]  owner;
    logic [NREQ-1:0] done;
    logic [IDW-1:0]  last;

    logic            win_valid;
    logic [IDW-1:0]  win_idx;
    logic [NREQ-1:0] win_onehot;

    // Round-robin search starting at last+1. The loop runs from the lowest
    // priority (offset NREQ, i.e. last itself) towards the highest, so the
    // final assignment that sticks belongs to the highest-priority requester.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        win_valid  = 1'b0;
        win_idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = (int'(last) + k) % NREQ;
            if (bus.i_req[idx]) begin
                win_valid = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
        win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            count <= '0;
            grant <= '0;
            busy  <= 1'b0;
            owner <= '0;
            done  <= '0;
            // Pointer on the last requester makes requester 0 top priority.
            last  <= IDW'(NREQ - 1);
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            done <= '0;
            if (state == RUN && count != 16'd0) begin
                // Window in progress: requests are ignored until the end.
                count <= count - 16'd1;
                if (count == 16'd1)
                    done <= grant;
            end
`ifdef TIMER_ARB_GAP_EN
            else if (state == RUN) begin
                // Last grant cycle: release the resource for one GAP cycle.
                state <= GAP;
                grant <= '0;
                busy  <= 1'b0;
            end
`endif
            else if (win_valid) begin
                // IDLE, GAP or last RUN cycle with a pending request.
                state <= RUN;
                count <= CNT_LOAD;
                grant <= win_onehot;
                busy  <= 1'b1;
                owner <= win_idx;
                last  <= win_idx;
                done  <= DONE_ON_LOAD ? win_onehot : '0;
            end else begin
                // Nothing pending: owner keeps the last grantee.
                state <= IDLE;
                grant <= '0;
                busy  <= 1'b0;
            end
        end
    end

    assign bus.o_grant = grant;
    assign bus.o_busy  = busy;
    assign bus.o_owner = owner;
    assign bus.o_done  = done;

`ifdef FORMAL
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            assert ($onehot0(grant));
            assert ($onehot0(done));
            assert (busy == |grant);
            assert ((done & ~grant) == '0);
            assert (32'(count) < DURATION);
        end
    end
`endif

endmodule

// File: tb/tb_busy_arbiter.sv
// -----------------------------------------------------------------------------
// tb_busy_arbiter
//
// Self-checking bench for busy_arbiter with NREQ=4. Two instances share the
// clock and reset: dut5 (DURATION=5) and dut1 (DURATION=1). Each table row
// gives the request driven during one cycle and the outputs expected in the
// following cycle; rows are pushed to a scoreboard queue when driven and
// popped and compared after the clock edge. Hand-written sequences cover the
// asynchronous mid-grant reset.
// -----------------------------------------------------------------------------
module tb_busy_arbiter;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic       busy;
        logic [1:0] owner;
        logic [3:0] done;
        bit         rst;   // pulse reset before this row
        bit         sel;   // 0: dut5, 1: dut1
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    busy_arbiter_if #(.NREQ(4), .IDW(2)) bus5 ();
    busy_arbiter_if #(.NREQ(4), .IDW(2)) bus1 ();

    busy_arbiter #(.NREQ(4), .DURATION(5), .IDW(2)) dut5 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus5.slave)
    );

    busy_arbiter #(.NREQ(4), .DURATION(1), .IDW(2)) dut1 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus1.slave)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t tbl[$];
    vec_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] grant,
                                input logic busy, input logic [1:0] owner,
                                input logic [3:0] done, input bit rst_b, input bit sel);
        vec_t v;
        v.req = req; v.grant = grant; v.busy = busy; v.owner = owner;
        v.done = done; v.rst = rst_b; v.sel = sel;
        return v;
    endfunction

    task automatic add(input logic [3:0] req, input logic [3:0] grant, input logic busy,
                       input logic [1:0] owner, input logic [3:0] done,
                       input bit rst_b = 1'b0, input bit sel = 1'b0);
        tbl.push_back(mk(req, grant, busy, owner, done, rst_b, sel));
    endtask

    task automatic check_idle_both(input string tag);
        check({tag, " dut5 grant"}, 32'(bus5.o_grant), 32'h0);
        check({tag, " dut5 busy"},  32'(bus5.o_busy),  32'h0);
        check({tag, " dut5 owner"}, 32'(bus5.o_owner), 32'h0);
        check({tag, " dut5 done"},  32'(bus5.o_done),  32'h0);
        check({tag, " dut1 grant"}, 32'(bus1.o_grant), 32'h0);
        check({tag, " dut1 done"},  32'(bus1.o_done),  32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus5.i_req = '0;
        bus1.i_req = '0;
        rst = 1'b1;
        #1;
        check_idle_both("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        bus5.i_req = v.sel ? 4'b0 : v.req;
        bus1.i_req = v.sel ? v.req : 4'b0;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.sel) begin
            check({tag, " dut1 grant"}, 32'(bus1.o_grant), 32'(e.grant));
            check({tag, " dut1 busy"},  32'(bus1.o_busy),  32'(e.busy));
            check({tag, " dut1 owner"}, 32'(bus1.o_owner), 32'(e.owner));
            check({tag, " dut1 done"},  32'(bus1.o_done),  32'(e.done));
        end else begin
            check({tag, " dut5 grant"}, 32'(bus5.o_grant), 32'(e.grant));
            check({tag, " dut5 busy"},  32'(bus5.o_busy),  32'(e.busy));
            check({tag, " dut5 owner"}, 32'(bus5.o_owner), 32'(e.owner));
            check({tag, " dut5 done"},  32'(bus5.o_done),  32'(e.done));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus5.i_req = '0;
        bus1.i_req = '0;

`ifdef TIMER_ARB_GAP_EN
        // Gap: 0011 held, one non-busy cycle between 5-cycle grants.
        for (int r = 0; r < 13; r++) begin
            if (r == 5 || r == 11)
                add(4'b0011, 4'b0000, 1'b0, (r == 5) ? 2'd0 : 2'd1, 4'b0000, r == 0);
            else if (r < 5 || r == 12)
                add(4'b0011, 4'b0001, 1'b1, 2'd0, (r == 4) ? 4'b0001 : 4'b0000, r == 0);
            else
                add(4'b0011, 4'b0010, 1'b1, 2'd1, (r == 10) ? 4'b0010 : 4'b0000);
        end
`else
        // Single request for one cycle.
        add(4'b0001, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b1);
        add(4'b0000, 4'b0001, 1'b1, 2'd0, 4'b0000);
        add(4'b0000, 4'b0001, 1'b1, 2'd0, 4'b0000);
        add(4'b0000, 4'b0001, 1'b1, 2'd0, 4'b0000);
        add(4'b0000, 4'b0001, 1'b1, 2'd0, 4'b0001);
        add(4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000);
        add(4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000);

        // All requesting: owners 0,1,2,3,0 in contiguous 5-cycle windows.
        for (int w = 0; w < 5; w++)
            for (int c = 0; c < 5; c++)
                add(4'b1111, 4'(1 << (w % 4)), 1'b1, 2'(w % 4),
                    (c == 4) ? 4'(1 << (w % 4)) : 4'b0000, (w == 0 && c == 0));

        // Lone holder: requester 2 re-granted back-to-back.
        for (int r = 0; r < 15; r++)
            add(4'b0100, 4'b0100, 1'b1, 2'd2, (r % 5 == 4) ? 4'b0100 : 4'b0000, r == 0);

        // Early drop of 0010 at t+2; 1000 raised at t+3 is granted at t+6.
        add(4'b0010, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b1);
        add(4'b0010, 4'b0010, 1'b1, 2'd1, 4'b0000);
        add(4'b0000, 4'b0010, 1'b1, 2'd1, 4'b0000);
        add(4'b1000, 4'b0010, 1'b1, 2'd1, 4'b0000);
        add(4'b1000, 4'b0010, 1'b1, 2'd1, 4'b0010);
        add(4'b1000, 4'b1000, 1'b1, 2'd3, 4'b0000);
        add(4'b0000, 4'b1000, 1'b1, 2'd3, 4'b0000);
        add(4'b0000, 4'b1000, 1'b1, 2'd3, 4'b0000);
        add(4'b0000, 4'b1000, 1'b1, 2'd3, 4'b0000);
        add(4'b0000, 4'b1000, 1'b1, 2'd3, 4'b1000);
        add(4'b0000, 4'b0000, 1'b0, 2'd3, 4'b0000);

        // DURATION=1: grant and done coincide; 0011 alternates 1,0,1.
        add(4'b0001, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1);
        add(4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1);
        add(4'b0011, 4'b0010, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b1);
        add(4'b0011, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b1);
        add(4'b0011, 4'b0010, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b1);
        add(4'b0000, 4'b0000, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b1);
`endif

        foreach (tbl[i]) begin
            if (tbl[i].rst)
                do_reset();
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // Mid-grant reset: outputs clear at once, pointer returns to NREQ-1.
        do_reset();
        apply(mk(4'b0010, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0), "mrst t+1");
        apply(mk(4'b0000, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0), "mrst t+2");
        apply(mk(4'b0000, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0), "mrst t+3");
        #2;
        rst = 1'b1;
        #1;
        check_idle_both("mrst async");
        @(negedge clk);
        rst = 1'b0;
        apply(mk(4'b1010, 4'b0010, 1'b1, 2'd1, 4'b0000, 1'b0, 1'b0), "mrst regrant");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
